// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one single-port RAM between a pixel write stream and a display read stream.
// Reads win contention until MAX_RD_RUN reads have starved a pending write; then one write goes through.
module spram_arbiter #(
   parameter int DEPTH      = 30000,
   parameter int RD_LAT     = 1,
   parameter int MAX_RD_RUN = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   input  logic [14:0] wr_addr,
   input  logic [11:0] wr_data,
   output logic        wr_ready,
   input  logic        rd_valid,
   input  logic [14:0] rd_addr,
   output logic        rd_ready,
   output logic        rd_data_valid,
   output logic [11:0] rd_data,
   output logic [14:0] spram_addr,
   output logic [11:0] spram_wr_data,
   output logic        spram_wre,
   input  logic [11:0] spram_rd_data,
   output logic        addr_err
);

   typedef enum logic {RD_PRI = 1'b0, WR_PRI = 1'b1} state_t;

   localparam logic [15:0] DEPTH_W = 16'(DEPTH);
   localparam logic [7:0]  MAX_W   = 8'(MAX_RD_RUN);

   state_t          state_q, state_d;
   logic [7:0]      run_cnt_q, run_cnt_d;
   logic [RD_LAT:0] rd_pipe_q, rd_pipe_d;
   logic [14:0]     spram_addr_q, spram_addr_d;
   logic [11:0]     spram_wr_data_q, spram_wr_data_d;
   logic            spram_wre_q, spram_wre_d;
   logic [11:0]     rd_data_q, rd_data_d;
   logic            rd_data_valid_q, rd_data_valid_d;
   logic            addr_err_q, addr_err_d;

   logic wr_go, rd_go, wr_in_rng, rd_in_rng;

   // Exactly one port is ready under contention; the loser is chosen by state alone.
   assign rd_ready  = !rst && !(wr_valid && (state_q == WR_PRI));
   assign wr_ready  = !rst && !(rd_valid && (state_q == RD_PRI));
   assign wr_go     = wr_valid && wr_ready;
   assign rd_go     = rd_valid && rd_ready;
   assign wr_in_rng = {1'b0, wr_addr} < DEPTH_W;
   assign rd_in_rng = {1'b0, rd_addr} < DEPTH_W;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RD_PRI;
         run_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         run_cnt_q <= run_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      run_cnt_d = run_cnt_q;
      if (wr_go) begin
         run_cnt_d = 8'd0;
         state_d   = RD_PRI;
      end else if (!wr_valid) begin
         run_cnt_d = 8'd0;
      end else if (rd_go) begin
         run_cnt_d = run_cnt_q + 8'd1;
         if (run_cnt_q + 8'd1 == MAX_W) state_d = WR_PRI;
      end
   end

   always_comb begin
      spram_addr_d    = spram_addr_q;
      spram_wr_data_d = spram_wr_data_q;
      spram_wre_d     = 1'b0;
      addr_err_d      = addr_err_q;
      if (wr_go) begin
         if (wr_in_rng) begin
            spram_addr_d    = wr_addr;
            spram_wr_data_d = wr_data;
            spram_wre_d     = 1'b1;
         end else begin
            addr_err_d = 1'b1;
         end
      end else if (rd_go) begin
         if (rd_in_rng) spram_addr_d = rd_addr;
         else           addr_err_d   = 1'b1;
      end
   end

   // Out-of-range reads never enter the pipe, so they produce no return pulse.
   always_comb begin
      rd_pipe_d       = {rd_pipe_q[RD_LAT-1:0], rd_go && rd_in_rng};
      rd_data_valid_d = rd_pipe_q[RD_LAT];
      rd_data_d       = rd_pipe_q[RD_LAT] ? spram_rd_data : rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pipe_q       <= '0;
         spram_addr_q    <= 15'd0;
         spram_wr_data_q <= 12'd0;
         spram_wre_q     <= 1'b0;
         rd_data_q       <= 12'd0;
         rd_data_valid_q <= 1'b0;
         addr_err_q      <= 1'b0;
      end else begin
         rd_pipe_q       <= rd_pipe_d;
         spram_addr_q    <= spram_addr_d;
         spram_wr_data_q <= spram_wr_data_d;
         spram_wre_q     <= spram_wre_d;
         rd_data_q       <= rd_data_d;
         rd_data_valid_q <= rd_data_valid_d;
         addr_err_q      <= addr_err_d;
      end
   end

   assign spram_addr    = spram_addr_q;
   assign spram_wr_data = spram_wr_data_q;
   assign spram_wre     = spram_wre_q;
   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_data_valid_q;
   assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: SPRAM behavioural model, transaction-level reference model with
// per-cycle compare, directed scenarios with literal expectations, then randomized traffic.
module tb_spram_arbiter;

   localparam int DEPTH  = 30000;
   localparam int RD_LAT = 1;
   localparam int MAXRUN = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid, rd_valid;
   logic [14:0] wr_addr, rd_addr;
   logic [11:0] wr_data;
   logic        wr_ready, rd_ready, rd_data_valid, spram_wre, addr_err;
   logic [11:0] rd_data, spram_wr_data, spram_rd_data;
   logic [14:0] spram_addr;

   int total = 0;
   int bad   = 0;

   spram_arbiter #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .MAX_RD_RUN(MAXRUN)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data),
      .spram_addr(spram_addr), .spram_wr_data(spram_wr_data), .spram_wre(spram_wre),
      .spram_rd_data(spram_rd_data), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] pat(input int a);
      return 12'((a * 37) ^ 'h5A5);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Registered single-port RAM: data for the address presented in a cycle appears RD_LAT edges later.
   logic [11:0] sram [0:32767];
   logic [11:0] rpipe [0:RD_LAT-1];
   bit mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int a = 0; a < 32768; a++) sram[a] <= pat(a);
         mem_init <= 1'b1;
      end else if (spram_wre) begin
         sram[spram_addr] <= spram_wr_data;
      end
      rpipe[0] <= sram[spram_addr];
      for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign spram_rd_data = rpipe[RD_LAT-1];

   // ---------------- reference model ----------------
   typedef struct { int cyc; logic [11:0] d; } rd_exp_t;
   rd_exp_t     exp_q[$];
   logic [11:0] ref_mem [0:32767];
   int          cyc = 0;
   bit          primed = 1'b0;
   bit          owed;       // a write has been starved MAXRUN reads and now takes priority
   int          streak;     // consecutive reads granted while a write was waiting
   logic        exp_wre, exp_err, ev, exp_wrdy, exp_rrdy, wg, rg;
   logic [14:0] exp_addr;
   logic [11:0] exp_wd, exp_rdata;

   initial begin : cmp
      for (int a = 0; a < 32768; a++) ref_mem[a] = pat(a);
      forever begin
         @(negedge clk);
         if (primed) begin
            ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            if (ev) begin
               exp_rdata = exp_q[0].d;
               void'(exp_q.pop_front());
            end
            chk("spram_wre", int'(spram_wre), int'(exp_wre));
            chk("spram_addr", int'(spram_addr), int'(exp_addr));
            chk("spram_wr_data", int'(spram_wr_data), int'(exp_wd));
            chk("addr_err", int'(addr_err), int'(exp_err));
            chk("rd_data_valid", int'(rd_data_valid), int'(ev));
            chk("rd_data", int'(rd_data), int'(exp_rdata));
         end
         exp_rrdy = !rst && !(wr_valid && owed);
         exp_wrdy = !rst && !(rd_valid && !owed);
         chk("rd_ready", int'(rd_ready), int'(exp_rrdy));
         chk("wr_ready", int'(wr_ready), int'(exp_wrdy));
         wg = wr_valid && exp_wrdy;
         rg = rd_valid && exp_rrdy;
         if (rst) begin
            exp_wre = 0; exp_addr = 0; exp_wd = 0; exp_rdata = 0; exp_err = 0;
            exp_q.delete();
            owed = 0; streak = 0; primed = 1;
         end else begin
            exp_wre = 0;
            if (wg) begin
               if (int'(wr_addr) < DEPTH) begin
                  exp_wre = 1; exp_addr = wr_addr; exp_wd = wr_data;
                  ref_mem[wr_addr] = wr_data;
               end else exp_err = 1;
               streak = 0; owed = 0;
            end else if (rg) begin
               if (int'(rd_addr) < DEPTH) begin
                  exp_addr = rd_addr;
                  exp_q.push_back('{cyc + RD_LAT + 2, ref_mem[rd_addr]});
               end else exp_err = 1;
               if (wr_valid) begin
                  streak++;
                  if (streak == MAXRUN) owed = 1;
               end
            end
            if (!wr_valid) streak = 0;
         end
         cyc++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic wv, input int wa, input int wd, input logic rv, input int ra);
      wr_valid = wv; wr_addr = 15'(wa); wr_data = 12'(wd);
      rd_valid = rv; rd_addr = 15'(ra);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   int nw, first_w, wait_c, max_w, cnt_a, cnt_b;

   initial begin
      rst = 1'b1;
      drive(1, 3, 1, 1, 4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_wr_ready", int'(wr_ready), 0);
         chk("rst_rd_ready", int'(rd_ready), 0);
         tick();
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      tick();

      // write 5 <= 0xABC, read it back
      drive(1, 5, 'hABC, 0, 0);
      @(negedge clk); chk("t036_wr_ready", int'(wr_ready), 1);
      tick();
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t036_wre", int'(spram_wre), 1);
      chk("t036_addr", int'(spram_addr), 5);
      chk("t036_wdata", int'(spram_wr_data), 'hABC);
      tick();
      drive(0, 0, 0, 1, 5);
      @(negedge clk); chk("t036_rd_ready", int'(rd_ready), 1);
      tick();
      drive(0, 0, 0, 0, 0);
      tick(); tick();
      @(negedge clk);
      chk("t036_rvalid", int'(rd_data_valid), 1);
      chk("t036_rdata", int'(rd_data), 'hABC);
      tick();

      // contention from a fresh arbiter: 8 reads then 1 write, repeating
      nw = 0; first_w = -1; wait_c = 0; max_w = 0;
      for (int k = 0; k < 18; k++) begin
         drive(1, 100 + k, 'h123 + k, 1, 7);
         @(negedge clk);
         if (wr_ready) begin
            nw++;
            if (first_w < 0) first_w = k;
            wait_c = 0;
         end else begin
            wait_c++;
            if (wait_c > max_w) max_w = wait_c;
         end
         tick();
      end
      chk("t037_wr_grants", nw, 2);
      chk("t037_first_wr", first_w, 8);
      chk("t037_max_wait", max_w, 8);
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick();

      // out-of-range write
      drive(1, 30000, 'h777, 0, 0);
      @(negedge clk); chk("t039_wr_ready", int'(wr_ready), 1);
      tick();
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t039_wre", int'(spram_wre), 0);
      chk("t039_err", int'(addr_err), 1);
      tick();
      drive(1, 20, 'h020, 0, 0); tick();
      drive(0, 0, 0, 1, 20); tick();
      drive(0, 0, 0, 0, 0); tick(); tick();
      @(negedge clk); chk("t039_err_sticky", int'(addr_err), 1);
      tick();

      // streaming 200 reads
      cnt_a = 0;
      for (int i = 0; i < 200; i++) begin
         drive(0, 0, 0, 1, i);
         @(negedge clk); if (rd_data_valid) cnt_a++;
         tick();
      end
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); if (rd_data_valid) cnt_a++;
         tick();
      end
      chk("t038_pulses", cnt_a, 200);

      // reset one cycle after two reads are accepted
      drive(0, 0, 0, 1, 10); tick();
      drive(0, 0, 0, 1, 11); tick();
      rst = 1'b1; drive(1, 12, 1, 1, 12);
      @(negedge clk);
      chk("t040_wr_ready", int'(wr_ready), 0);
      chk("t040_rd_ready", int'(rd_ready), 0);
      tick();
      rst = 1'b0; drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t040_wre", int'(spram_wre), 0);
      chk("t040_addr", int'(spram_addr), 0);
      chk("t040_wdata", int'(spram_wr_data), 0);
      chk("t040_rdata", int'(rd_data), 0);
      chk("t040_err", int'(addr_err), 0);
      cnt_b = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); if (rd_data_valid) cnt_b++;
         tick();
      end
      chk("t040_no_pulse", cnt_b, 0);

      // write-only fill of the whole array
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, i, i ^ 'h3C3, 0, 0);
         @(negedge clk);
         if (wr_ready) cnt_a++;
         if (spram_wre) cnt_b++;
         tick();
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk); if (spram_wre) cnt_b++;
      tick();
      chk("t041_ready_cycles", cnt_a, DEPTH);
      chk("t041_writes", cnt_b, DEPTH);

      // randomized mixed traffic
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         drive($urandom_range(0, 2) != 0,
               ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, 32767) : $urandom_range(0, 63),
               $urandom_range(0, 4095),
               $urandom_range(0, 3) != 0,
               ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH, 32767) : $urandom_range(0, 63));
         tick();
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) tick();
      chk("drain_queue", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
